// File: rtl/ram_port_arbiter_if.sv
// Master/slave view of one dual-port byte-wide block RAM.
// Port a is driven by the arbiter. Port b is available to other logic.
interface ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTE_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [BYTE_WIDTH-1:0] write_a;
  logic                  write_en_a;
  logic [BYTE_WIDTH-1:0] data_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [BYTE_WIDTH-1:0] write_b;
  logic                  write_en_b;
  logic [BYTE_WIDTH-1:0] data_b;

  modport m (output addr_a, output write_a, output write_en_a, input data_a);
  modport s (input addr_a, input write_a, input write_en_a, output data_a,
             input addr_b, input write_b, input write_en_b, output data_b);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port a among N_REQ requesters, with 1-cycle responses.
// Optional grant lock for read-modify-write sequences: define RAM_ARB_LOCK_EN.
module ram_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*BYTE_WIDTH-1:0]   req_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]              req_lock,
`endif
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [BYTE_WIDTH-1:0]         rsp_rdata,
  ram_if.m                              ram
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_rsp_id;
  logic             r_rsp_pend;
  logic             r_rsp_we;
  logic [N_REQ-1:0] w_eligible;
  logic             w_grant_vld;
  logic [PTR_W-1:0] w_grant_id;
  logic             w_advance;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_owner;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_grant_vld && req_lock[w_grant_id])
        r_owner <= w_grant_id;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:    if (w_grant_vld && req_lock[w_grant_id])  w_state_nxt = LOCKED;
      LOCKED: if (w_grant_vld && !req_lock[w_grant_id]) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // While locked only the owner may compete; the pointer moves only on an unlocked grant.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < N_REQ; i++)
      w_eligible[i] = req_valid[i] && (r_state == ARB || r_owner == PTR_W'(i));
    w_advance = w_grant_vld && !req_lock[w_grant_id];
  end
`else
  always_comb begin
    w_eligible = req_valid;
    w_advance  = w_grant_vld;
  end
`endif

  // First eligible requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rst_n && !w_grant_vld && w_eligible[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready      = '0;
    ram.addr_a     = '0;
    ram.write_a    = '0;
    ram.write_en_a = 1'b0;
    if (w_grant_vld) begin
      req_ready[w_grant_id] = 1'b1;
      ram.addr_a     = req_addr[int'(w_grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      ram.write_a    = req_wdata[int'(w_grant_id)*BYTE_WIDTH +: BYTE_WIDTH];
      ram.write_en_a = req_we[w_grant_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_advance) begin
      r_rr_ptr <= (w_grant_id == PTR_W'(N_REQ - 1)) ? '0 : w_grant_id + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_pend <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_we   <= 1'b0;
    end else begin
      r_rsp_pend <= w_grant_vld;
      if (w_grant_vld) begin
        r_rsp_id <= w_grant_id;
        r_rsp_we <= req_we[w_grant_id];
      end
    end
  end

  // Gating with rst_n hides a response whose cycle coincides with an asserted reset.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rst_n && r_rsp_pend) begin
      rsp_valid[r_rsp_id] = 1'b1;
      if (!r_rsp_we) rsp_rdata = ram.data_a;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a write-first RAM model on port a.
// Lock scenarios compile only when RAM_ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*BW-1:0] req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif
  logic [N-1:0]    rsp_valid;
  logic [BW-1:0]   rsp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  ram_if #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) ram_bus ();

  ram_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef RAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram       (ram_bus)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM on port a; port b idle.
  logic [BW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_bus.write_en_a) begin
      mem[ram_bus.addr_a] <= ram_bus.write_a;
      ram_bus.data_a      <= ram_bus.write_a;
    end else begin
      ram_bus.data_a <= mem[ram_bus.addr_a];
    end
  end
  assign ram_bus.addr_b     = '0;
  assign ram_bus.write_b    = '0;
  assign ram_bus.write_en_b = 1'b0;
  assign ram_bus.data_b     = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*BW +: BW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    req_lock  = '0;
`endif
  endtask

  // Leaves the bench at a negedge with reset released; the next posedge is the first live one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    req_we    = '1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(16'h1234 + i), BW'(8'h5A));
    @(negedge clk);
    #1;
    if (req_ready !== 4'b0000) begin $display("FAIL reset_ready: got %b expected 0000", req_ready); n_err++; end n_cmp++;
    if (ram_bus.write_en_a !== 1'b0) begin $display("FAIL reset_we: got %b expected 0", ram_bus.write_en_a); n_err++; end n_cmp++;
    if (ram_bus.addr_a !== 16'h0000) begin $display("FAIL reset_addr: got %h expected 0000", ram_bus.addr_a); n_err++; end n_cmp++;
    if (ram_bus.write_a !== 8'h00) begin $display("FAIL reset_wdata: got %h expected 00", ram_bus.write_a); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b0000) begin $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); n_err++; end n_cmp++;
    if (rsp_rdata !== 8'h00) begin $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); n_err++; end n_cmp++;
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(16'h0100 + i), 8'h00);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready !== 4'(1 << exp_g[c])) begin
        $display("FAIL fair_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << exp_g[c])); n_err++;
      end
      n_cmp++;
      if (c > 0) begin
        if (rsp_valid !== 4'(1 << exp_g[c-1])) begin
          $display("FAIL fair_rsp[%0d]: got %b expected %b", c, rsp_valid, 4'(1 << exp_g[c-1])); n_err++;
        end
        n_cmp++;
      end
      @(negedge clk);
    end
    clear_reqs();
    #1;
    if (rsp_valid !== 4'b1000) begin $display("FAIL fair_rsp_last: got %b expected 1000", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0010, 8'hA5);
    #1;
    if (req_ready !== 4'b0001) begin $display("FAIL sr_wr_ready: got %b expected 0001", req_ready); n_err++; end n_cmp++;
    if (ram_bus.write_en_a !== 1'b1) begin $display("FAIL sr_wr_en: got %b expected 1", ram_bus.write_en_a); n_err++; end n_cmp++;
    if (ram_bus.addr_a !== 16'h0010) begin $display("FAIL sr_wr_addr: got %h expected 0010", ram_bus.addr_a); n_err++; end n_cmp++;
    if (ram_bus.write_a !== 8'hA5) begin $display("FAIL sr_wr_data: got %h expected a5", ram_bus.write_a); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 16'h0010, 8'h00);
    #1;
    if (req_ready !== 4'b0100) begin $display("FAIL sr_rd_ready: got %b expected 0100", req_ready); n_err++; end n_cmp++;
    if (ram_bus.write_en_a !== 1'b0) begin $display("FAIL sr_rd_we: got %b expected 0", ram_bus.write_en_a); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b0001) begin $display("FAIL sr_wr_rsp: got %b expected 0001", rsp_valid); n_err++; end n_cmp++;
    if (rsp_rdata !== 8'h00) begin $display("FAIL sr_wr_rdata: got %h expected 00", rsp_rdata); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 4'b0100) begin $display("FAIL sr_rd_rsp: got %b expected 0100", rsp_valid); n_err++; end n_cmp++;
    if (rsp_rdata !== 8'hA5) begin $display("FAIL sr_rd_rdata: got %h expected a5", rsp_rdata); n_err++; end n_cmp++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 4'b0000) begin $display("FAIL sr_idle_rsp: got %b expected 0000", rsp_valid); n_err++; end n_cmp++;
  endtask

  task automatic test_skip_wrap();
    int exp_g [4] = '{3, 1, 3, 1};
    do_reset();
    set_req(1, 1'b1, 1'b0, 16'h0200, 8'h00);
    #1;
    if (req_ready !== 4'b0010) begin $display("FAIL sw_setup: got %b expected 0010", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, 16'h0203, 8'h00);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (req_ready !== 4'(1 << exp_g[c])) begin
        $display("FAIL sw_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << exp_g[c])); n_err++;
      end
      n_cmp++;
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_write_read_pair();
    do_reset();
    set_req(1, 1'b1, 1'b1, 16'h00FF, 8'h3C);
    #1;
    if (req_ready !== 4'b0010) begin $display("FAIL wr_ready: got %b expected 0010", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 16'h00FF, 8'h00);
    #1;
    if (req_ready !== 4'b0100) begin $display("FAIL wr_rd_ready: got %b expected 0100", req_ready); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b0010) begin $display("FAIL wr_wr_rsp: got %b expected 0010", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_valid !== 4'b0100) begin $display("FAIL wr_rd_rsp: got %b expected 0100", rsp_valid); n_err++; end n_cmp++;
    if (rsp_rdata !== 8'h3C) begin $display("FAIL wr_rd_rdata: got %h expected 3c", rsp_rdata); n_err++; end n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0050, 8'h11);
    set_req(3, 1'b1, 1'b1, 16'h0051, 8'h22);
    #1;
    if (req_ready !== 4'b0001) begin $display("FAIL b2b_c0: got %b expected 0001", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h0050, 8'h00);
    #1;
    if (req_ready !== 4'b0010) begin $display("FAIL b2b_c1: got %b expected 0010", req_ready); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b0001) begin $display("FAIL b2b_c1_rsp: got %b expected 0001", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    if (req_ready !== 4'b1000) begin $display("FAIL b2b_c2: got %b expected 1000", req_ready); n_err++; end n_cmp++;
    if (rsp_rdata !== 8'h11) begin $display("FAIL b2b_c2_rdata: got %h expected 11", rsp_rdata); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 16'h0051, 8'h00);
    #1;
    if (req_ready !== 4'b0100) begin $display("FAIL b2b_c3: got %b expected 0100", req_ready); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b1000) begin $display("FAIL b2b_c3_rsp: got %b expected 1000", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
    #1;
    if (rsp_rdata !== 8'h22) begin $display("FAIL b2b_c4_rdata: got %h expected 22", rsp_rdata); n_err++; end n_cmp++;
    @(negedge clk);
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0020, 8'h00);
    req_lock[0] = 1'b1;
    set_req(1, 1'b1, 1'b0, 16'h0030, 8'h00);
    #1;
    if (req_ready !== 4'b0001) begin $display("FAIL lock_enter: got %b expected 0001", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    if (req_ready !== 4'b0000) begin $display("FAIL lock_hold: got %b expected 0000", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 16'h0020, 8'h77);
    req_lock[0] = 1'b0;
    #1;
    if (req_ready !== 4'b0001) begin $display("FAIL lock_leave: got %b expected 0001", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    if (req_ready !== 4'b0010) begin $display("FAIL lock_next: got %b expected 0010", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
  endtask
`endif

  task automatic test_reset_mid_op();
    do_reset();
    set_req(2, 1'b1, 1'b0, 16'h0040, 8'h00);
`ifdef RAM_ARB_LOCK_EN
    req_lock[2] = 1'b1;
`endif
    #1;
    if (req_ready !== 4'b0100) begin $display("FAIL rmo_grant: got %b expected 0100", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    #1;
    if (rsp_valid !== 4'b0000) begin $display("FAIL rmo_rsp_in_reset: got %b expected 0000", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 4'b0000) begin $display("FAIL rmo_rsp_after: got %b expected 0000", rsp_valid); n_err++; end n_cmp++;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(16'h0300 + i), 8'h00);
    #1;
    if (req_ready !== 4'b0001) begin $display("FAIL rmo_first: got %b expected 0001", req_ready); n_err++; end n_cmp++;
    if (rsp_valid !== 4'b0000) begin $display("FAIL rmo_rsp_release: got %b expected 0000", rsp_valid); n_err++; end n_cmp++;
    @(negedge clk);
    #1;
    if (req_ready !== 4'b0010) begin $display("FAIL rmo_second: got %b expected 0010", req_ready); n_err++; end n_cmp++;
    @(negedge clk);
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_skip_wrap();
    test_write_read_pair();
    test_back_to_back();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
